// File: rtl/fsk_tx_scheduler.sv
// Two-requester round-robin scheduler that frames each accepted 9-bit word as a
// start pulse, an alternating preamble and three 3-bit FSK symbols.
module fsk_tx_scheduler #(
  parameter int SYM_CYCLES   = 100,
  parameter int PREAMBLE_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       req0_valid,
  input  logic [8:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [8:0] req1_data,
  output logic       req1_ready,
  output logic [2:0] sym_out,
  output logic       mod_start,
  output logic       sym_strobe,
  output logic [1:0] grant,
  output logic       busy
);
  localparam int HOLD_W = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam int IDX_W  = $clog2(PREAMBLE_LEN + 3);

  localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(SYM_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_PRE_LAST = IDX_W'(PREAMBLE_LEN - 1);
  localparam logic [IDX_W-1:0]  IDX_DATA0    = IDX_W'(PREAMBLE_LEN);
  localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(PREAMBLE_LEN + 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_PREAMBLE, S_DATA} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [HOLD_W-1:0] r_hold;
  logic [IDX_W-1:0]  r_idx;
  logic [8:0]        r_data;
  logic [1:0]        r_grant;
  logic              r_prio1;
  logic              w_sel0;
  logic              w_sel1;
  logic              w_can_grant;
  logic              w_xfer;
  logic              w_active;
  logic              w_sym_end;

  function automatic logic [2:0] data_sym(input logic [8:0] d, input logic [IDX_W-1:0] didx);
    case (didx)
      IDX_W'(0): data_sym = d[8:6];
      IDX_W'(1): data_sym = d[5:3];
      default:   data_sym = d[2:0];
    endcase
  endfunction

  // r_prio1 set means a tie goes to req1; it always points away from the last winner.
  assign w_sel0      = req0_valid & (~req1_valid | ~r_prio1);
  assign w_sel1      = req1_valid & (~req0_valid | r_prio1);
  assign w_can_grant = (r_state == S_IDLE) & enable & ~reset;
  assign req0_ready  = w_can_grant & w_sel0;
  assign req1_ready  = w_can_grant & w_sel1;
  assign w_xfer      = req0_ready | req1_ready;

  assign w_active  = (r_state == S_PREAMBLE) | (r_state == S_DATA);
  assign w_sym_end = w_active & (r_hold == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_xfer) w_next = S_START;
      S_START:    w_next = S_PREAMBLE;
      S_PREAMBLE: if (w_sym_end && (r_idx == IDX_PRE_LAST)) w_next = S_DATA;
      S_DATA:     if (w_sym_end && (r_idx == IDX_LAST)) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Symbol index runs straight through preamble into data; hold counter restarts per symbol.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= '0;
      r_idx  <= '0;
    end else if (!w_active) begin
      r_hold <= '0;
      r_idx  <= '0;
    end else if (w_sym_end) begin
      r_hold <= '0;
      r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_hold <= r_hold + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant <= 2'b00;
      r_prio1 <= 1'b0;
    end else if (w_xfer) begin
      r_grant <= {req1_ready, req0_ready};
      r_prio1 <= req0_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer) r_data <= req0_ready ? req0_data : req1_data;
  end

  always_comb begin
    sym_out = 3'b000;
    case (r_state)
      S_PREAMBLE: sym_out = {3{r_idx[0]}};
      S_DATA:     sym_out = data_sym(r_data, r_idx - IDX_DATA0);
      default:    sym_out = 3'b000;
    endcase
  end

  assign mod_start  = (r_state == S_START);
  assign sym_strobe = w_active & (r_hold == '0);
  assign busy       = (r_state != S_IDLE);
  assign grant      = busy ? r_grant : 2'b00;
endmodule

// File: tb/tb_fsk_tx_scheduler.sv
// Scoreboard bench for fsk_tx_scheduler: directed frames push expected ready,
// start, symbol and end-of-frame events; a negedge monitor pops and compares.
module tb_fsk_tx_scheduler;
  localparam int SYM   = 100;
  localparam int PRE   = 4;
  localparam int FRAME = 2 + (PRE + 3) * SYM;
  localparam int NOCUT = 32'h7fff_ffff;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [8:0] req0_data, req1_data;
  logic [2:0] sym_out;
  logic       mod_start, sym_strobe, busy;
  logic [1:0] grant;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    int         n;
    logic [2:0] val;
    logic [1:0] gnt;
  } ev_t;

  ev_t q_rdy[$];
  ev_t q_start[$];
  ev_t q_sym[$];
  ev_t q_end[$];

  fsk_tx_scheduler #(.SYM_CYCLES(SYM), .PREAMBLE_LEN(PRE)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .sym_out(sym_out), .mod_start(mod_start), .sym_strobe(sym_strobe),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event with nothing expected at cycle %0d", name, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // cut = first cycle back in IDLE after a mid-frame reset (NOCUT for a full frame)
  task automatic expect_frame(input int t, input logic [1:0] g, input logic [8:0] d, input int cut);
    ev_t e;
    int  n = 0;
    e.gnt = g; e.n = 0; e.val = 3'b000;
    e.cyc = t;
    q_rdy.push_back(e);
    e.cyc = t + 1;
    if (e.cyc < cut) q_start.push_back(e);
    for (int k = 0; k < PRE + 3; k++) begin
      e.cyc = t + 2 + k * SYM;
      if (k < PRE)         e.val = (k % 2 == 1) ? 3'b111 : 3'b000;
      else if (k == PRE)   e.val = d[8:6];
      else if (k == PRE+1) e.val = d[5:3];
      else                 e.val = d[2:0];
      if (e.cyc < cut) begin
        q_sym.push_back(e);
        n++;
      end
    end
    e.n   = n;
    e.val = 3'b000;
    e.cyc = (cut < t + FRAME) ? cut : t + FRAME;
    q_end.push_back(e);
  endtask

  initial begin : monitor
    ev_t        e;
    logic       prev_busy = 1'b0;
    logic [2:0] prev_sym = 3'b000;
    int         nstb = 0;
    int         nhold = 0;
    forever begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        if (q_rdy.size() == 0) unexpected("ready");
        else begin
          e = q_rdy.pop_front();
          chk("ready_cycle", cyc, e.cyc);
          chk("ready_which", {req1_ready, req0_ready}, e.gnt);
        end
      end
      if (mod_start) begin
        if (q_start.size() == 0) unexpected("mod_start");
        else begin
          e = q_start.pop_front();
          chk("start_cycle", cyc, e.cyc);
          chk("start_grant", grant, e.gnt);
          chk("start_sym", sym_out, 3'b000);
        end
        nstb  = 0;
        nhold = 0;
      end
      if (sym_strobe) begin
        nstb++;
        if (q_sym.size() == 0) unexpected("sym_strobe");
        else begin
          e = q_sym.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("sym_value", sym_out, e.val);
          chk("sym_grant", grant, e.gnt);
        end
      end else if (busy && prev_busy && !mod_start && sym_out !== prev_sym) begin
        nhold++;
      end
      if (prev_busy && !busy) begin
        if (q_end.size() == 0) unexpected("frame_end");
        else begin
          e = q_end.pop_front();
          chk("end_cycle", cyc, e.cyc);
          chk("strobes_per_frame", nstb, e.n);
          chk("hold_violations", nhold, 0);
          chk("idle_sym", sym_out, 3'b000);
          chk("idle_grant", grant, 2'b00);
        end
      end
      prev_busy = busy;
      prev_sym  = sym_out;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int t;
    reset = 1'b1; enable = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 9'd0; req1_data = 9'd0;
    tick(3);
    chk("rst_sym_out", sym_out, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_mod_start", mod_start, 1'b0);
    chk("rst_sym_strobe", sym_strobe, 1'b0);
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);

    // req0 alone; data changed after acceptance must not leak into the frame
    req0_valid = 1'b0; req1_valid = 1'b0; reset = 1'b0;
    tick(2);
    req0_data = 9'b001_010_011; req0_valid = 1'b1;
    t = cyc;
    expect_frame(t, 2'b01, 9'b001_010_011, NOCUT);
    tick(1);
    req0_valid = 1'b0; req0_data = 9'b111_111_111;
    tick(FRAME + 5);

    // Both valid from the first cycle after reset, held for four frames
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 9'b010_100_110; req1_data = 9'b101_011_001;
    tick(2);
    reset = 1'b0;
    t = cyc;
    expect_frame(t,             2'b01, 9'b010_100_110, NOCUT);
    expect_frame(t + FRAME,     2'b10, 9'b101_011_001, NOCUT);
    expect_frame(t + 2 * FRAME, 2'b01, 9'b110_001_101, NOCUT);
    expect_frame(t + 3 * FRAME, 2'b10, 9'b101_011_001, NOCUT);
    tick(100);
    req0_data = 9'b110_001_101;
    tick(3 * FRAME + 1 - 100);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(FRAME + 5);

    // Tie won by req0, then reset in the DATA phase: req0 must win the next tie
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = 9'b010_010_010; req1_data = 9'b001_001_001;
    t = cyc;
    expect_frame(t, 2'b01, 9'b010_010_010, t + 551);
    tick(1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(549);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("post_reset_sym_out", sym_out, 3'b000);
    chk("post_reset_busy", busy, 1'b0);
    chk("post_reset_grant", grant, 2'b00);
    req0_data = 9'b011_101_110;
    req0_valid = 1'b1; req1_valid = 1'b1;
    expect_frame(cyc, 2'b01, 9'b011_101_110, NOCUT);
    tick(1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(FRAME + 5);

    // enable drops at T+300; frame unchanged, no ready until enable returns
    req1_data = 9'b011_110_100; req1_valid = 1'b1;
    t = cyc;
    expect_frame(t, 2'b10, 9'b011_110_100, NOCUT);
    tick(1);
    req1_valid = 1'b0;
    req0_data = 9'b100_000_010; req0_valid = 1'b1;
    tick(299);
    enable = 1'b0;
    tick(405);
    chk("disabled_idle_busy", busy, 1'b0);
    chk("disabled_req0_ready", req0_ready, 1'b0);
    tick(5);
    enable = 1'b1;
    expect_frame(t + 710, 2'b01, 9'b100_000_010, NOCUT);
    tick(1);
    req0_valid = 1'b0;
    tick(FRAME + 5);

    // Repeated 111 data symbols still get their own strobe
    req1_data = 9'b111_111_000; req1_valid = 1'b1;
    expect_frame(cyc, 2'b10, 9'b111_111_000, NOCUT);
    tick(1);
    req1_valid = 1'b0;
    tick(FRAME + 5);

    chk("pending_events", q_rdy.size() + q_start.size() + q_sym.size() + q_end.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fsk_tx_scheduler.md
FSK_TX_SCHEDULER -- requirements
Module: fsk_tx_scheduler

Interface
REQ-001 Parameter SYM_CYCLES, default 100, clock cycles each symbol is held on sym_out (legal range >= 2).
REQ-002 Parameter PREAMBLE_LEN, default 4, preamble symbols sent before each data word (legal range >= 1).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  when low, no new grants; a frame in progress still completes.
REQ-006 req0_valid  input  1  requester 0 holds a word to send.
REQ-007 req0_data  input  9  three 3-bit symbols; bits [8:6] are sent first.
REQ-008 req0_ready  output  1  word accepted from requester 0 this cycle.
REQ-009 req1_valid / req1_data / req1_ready  same widths and meaning as REQ-006 to REQ-008, for requester 1.
REQ-010 sym_out  output  3  symbol driven to the modulator data_in.
REQ-011 mod_start  output  1  one-cycle start pulse to the modulator.
REQ-012 sym_strobe  output  1  one-cycle pulse on the first cycle of each new symbol.
REQ-013 grant  output  2  one-hot owner of the current frame; 2'b00 when idle.
REQ-014 busy  output  1  high while a frame is in progress.

Function
REQ-015 FSM states SHALL be IDLE, START, PREAMBLE, DATA; a frame SHALL be PREAMBLE_LEN+3 symbols.
REQ-016 Arbitration in IDLE with enable=1 SHALL be:
- one requester valid: grant it;
- both valid: grant the requester not granted last (round-robin pointer).
REQ-017 reqN_ready SHALL be combinational and high only in IDLE, with enable=1, for the selected requester.
- Transfer occurs when valid and ready are both high in cycle T.
- At most one ready is high in any cycle.
REQ-018 On transfer at T, the block SHALL:
- latch data and grant;
- flip the round-robin pointer;
- enter START at T+1.
REQ-019 START SHALL last one cycle (T+1), with mod_start=1, sym_out=3'b000, busy=1.
REQ-020 PREAMBLE SHALL begin at T+2 and send PREAMBLE_LEN symbols alternating 3'b000, 3'b111, starting with 3'b000.
REQ-021 DATA SHALL send latched bits [8:6], then [5:3], then [2:0].
REQ-022 Each symbol SHALL be held exactly SYM_CYCLES cycles, with sym_strobe high on its first cycle only.
REQ-023 The hold counter width SHALL be clog2(SYM_CYCLES); the symbol index counter SHALL wrap cleanly from preamble into data with no extra cycle.
REQ-024 After the last data symbol's final cycle, the block SHALL return to IDLE at T+2+(PREAMBLE_LEN+3)*SYM_CYCLES.
- In IDLE: sym_out=3'b000, busy=0, grant=2'b00.
- A new transfer MAY occur in that same IDLE cycle.
REQ-025 Requester inputs SHALL be ignored outside IDLE; reqN_data SHALL be sampled only at transfer.
REQ-026 enable falling mid-frame SHALL NOT shorten or alter the frame; enable rising in IDLE SHALL allow a grant that same cycle.
REQ-027 A valid signal that drops before it is granted SHALL NOT produce a transfer or move the pointer.

Reset
REQ-028 While reset=1 at a clock edge, the next state SHALL be:
- FSM=IDLE; sym_out=3'b000; mod_start=0; sym_strobe=0; busy=0; grant=2'b00;
- both ready outputs 0;
- counters 0;
- round-robin pointer favouring req0.
REQ-029 Reset mid-frame SHALL abandon the frame, with no further mod_start or strobe until a new transfer.

Verification (SYM_CYCLES=100, PREAMBLE_LEN=4)
REQ-030 req0 alone, data 9'b001_010_011, accepted at T -> the bench SHALL check:
- mod_start at T+1;
- sym_out 000,111,000,111,001,010,011, each 100 cycles, starting at T+2;
- IDLE at T+702;
- req0_ready high only at T.
REQ-031 Both requesters valid in the first cycle after reset -> req0 granted first; req1_ready high at T+702 and its frame runs back-to-back.
REQ-032 Both requesters continuously valid for 4 frames -> grant sequence 01,10,01,10 (req0, req1, req0, req1).
REQ-033 enable dropped at T+300 of a frame -> frame completes unchanged; no ready while enable=0; grant in the same cycle enable returns.
REQ-034 Reset at T+550 (DATA phase) -> next cycle sym_out=000, busy=0, grant=00; with both valid afterwards, req0 wins.
REQ-035 Data 9'b111_111_000 -> the bench SHALL check:
- 3 data symbols with sym_strobe on each boundary, including between the two identical 111 symbols;
- exactly 7 strobes per frame.
